// File: rtl/tqvp_bus_initiator.sv
// tqvp_bus_initiator
// Host-side initiator for the TinyQV peripheral bus. Commands queue in a
// small FIFO and are replayed onto the peripheral address/data/strobe
// interface one at a time. Each command produces exactly one response
// carrying read data and a status code.
//
// Build option: define TQVP_BUS_INITIATOR_TIMEOUT_EN to abort reads that
// see TIMEOUT consecutive not-ready cycles (status 01). Without it, reads
// wait indefinitely for periph_data_ready.
module tqvp_bus_initiator #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic        clk,
  input  logic        rst,
  // command port
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [1:0]  cmd_size,
  input  logic [5:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  // response port
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_status,
  // peripheral bus
  output logic [5:0]  periph_address,
  output logic [31:0] periph_data_in,
  output logic [1:0]  periph_data_write_n,
  output logic [1:0]  periph_data_read_n,
  input  logic [31:0] periph_data_out,
  input  logic        periph_data_ready,
  // status
  output logic        busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [1:0] SIZE_ILLEGAL = 2'b11;
  localparam logic [1:0] STROBE_OFF   = 2'b11;
  localparam logic [1:0] ST_OK        = 2'b00;
  localparam logic [1:0] ST_ILLEGAL   = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  typedef struct packed {
    logic        write;
    logic [1:0]  size;
    logic [5:0]  addr;
    logic [31:0] wdata;
  } cmd_t;

  // Parameter sanity: the pointer scheme needs a power-of-two depth.
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("tqvp_bus_initiator: FIFO_DEPTH must be a power of two >= 2");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("tqvp_bus_initiator: TIMEOUT must be >= 1");
  end

  // ---------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------
  cmd_t           fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0] wr_ptr_q;
  logic [PTR_W:0] rd_ptr_q;
  logic           fifo_full;
  logic           fifo_empty;
  logic           push;
  logic           pop;
  cmd_t           cmd_in;
  cmd_t           head;

  // Extra pointer MSB distinguishes full from empty when indices match.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

  // A full FIFO refuses a push even if the FSM pops in the same cycle.
  assign cmd_ready = !fifo_full;
  assign push      = cmd_valid && !fifo_full;

  assign cmd_in = '{write: cmd_write, size: cmd_size, addr: cmd_addr, wdata: cmd_wdata};
  assign head   = fifo_mem[rd_ptr_q[PTR_W-1:0]];

  // Storage write; entries are only ever read after being written.
  // NOTE: the storage array has no reset -- validity is tracked by the
  // pointers, so clearing the data would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q[PTR_W-1:0]] <= cmd_in;
    end
  end

  // Read/write pointer advance.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + (PTR_W+1)'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + (PTR_W+1)'(1);
    end
  end

  // ---------------------------------------------------------------------
  // Transfer FSM with registered bus and response outputs
  // ---------------------------------------------------------------------
  state_t      state_q,     state_d;
  logic        cur_write_q, cur_write_d;
  logic [1:0]  cur_size_q,  cur_size_d;
  logic [5:0]  addr_q,      addr_d;
  logic [31:0] wdata_q,     wdata_d;
  logic [1:0]  write_n_q,   write_n_d;
  logic [1:0]  read_n_q,    read_n_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]  rsp_status_q, rsp_status_d;
  logic        tmo_hit;

  // Zero-extend read data to the transfer size.
  function automatic logic [31:0] size_mask(input logic [1:0] size,
                                            input logic [31:0] data);
    case (size)
      2'b00:   return {24'h0, data[7:0]};
      2'b01:   return {16'h0, data[15:0]};
      default: return data;
    endcase
  endfunction

`ifdef TQVP_BUS_INITIATOR_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_cnt_q;

  // The edge that would bring the count to TIMEOUT is the abort edge.
  assign tmo_hit = (tmo_cnt_q == TMO_W'(TIMEOUT - 1));

  // Count not-ready read cycles; cleared whenever a new command is launched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_q <= '0;
    end else if (pop) begin
      tmo_cnt_q <= '0;
    end else if (state_q == ACCESS && !cur_write_q && !periph_data_ready) begin
      tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Next-state, pop decision and next values of all registered outputs.
  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    cur_write_d  = cur_write_q;
    cur_size_d   = cur_size_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    write_n_d    = write_n_q;
    read_n_d     = read_n_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_status_d = rsp_status_q;
    pop          = 1'b0;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) pop = 1'b1;
      end

      ACCESS: begin
        if (cur_write_q || periph_data_ready || tmo_hit) begin
          // Bus cycle ends: release the bus and post the response.
          state_d      = RESP;
          addr_d       = '0;
          wdata_d      = '0;
          write_n_d    = STROBE_OFF;
          read_n_d     = STROBE_OFF;
          rsp_valid_d  = 1'b1;
          rsp_rdata_d  = '0;
          rsp_status_d = ST_OK;
          if (!cur_write_q) begin
            // Data arriving on the abort edge wins over the timeout.
            if (periph_data_ready) begin
              rsp_rdata_d = size_mask(cur_size_q, periph_data_out);
            end else begin
              rsp_status_d = 2'b01;
            end
          end
        end
      end

      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d  = 1'b0;
          rsp_rdata_d  = '0;
          rsp_status_d = ST_OK;
          if (fifo_empty) state_d = IDLE;
          else            pop     = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    // Launch the FIFO head, from IDLE or straight out of a completed RESP.
    if (pop) begin
      cur_write_d = head.write;
      cur_size_d  = head.size;
      if (head.size == SIZE_ILLEGAL) begin
        state_d      = RESP;
        rsp_valid_d  = 1'b1;
        rsp_rdata_d  = '0;
        rsp_status_d = ST_ILLEGAL;
      end else begin
        state_d   = ACCESS;
        addr_d    = head.addr;
        wdata_d   = head.wdata;
        write_n_d = head.write ? head.size : STROBE_OFF;
        read_n_d  = head.write ? STROBE_OFF : head.size;
      end
    end
  end

  // State and output registers; reset idles the bus immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cur_write_q  <= 1'b0;
      cur_size_q   <= 2'b00;
      addr_q       <= '0;
      wdata_q      <= '0;
      write_n_q    <= STROBE_OFF;
      read_n_q     <= STROBE_OFF;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_status_q <= ST_OK;
    end else begin
      state_q      <= state_d;
      cur_write_q  <= cur_write_d;
      cur_size_q   <= cur_size_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      write_n_q    <= write_n_d;
      read_n_q     <= read_n_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_status_q <= rsp_status_d;
    end
  end

  assign periph_address      = addr_q;
  assign periph_data_in      = wdata_q;
  assign periph_data_write_n = write_n_q;
  assign periph_data_read_n  = read_n_q;
  assign rsp_valid           = rsp_valid_q;
  assign rsp_rdata           = rsp_rdata_q;
  assign rsp_status          = rsp_status_q;
  assign busy                = !fifo_empty || (state_q != IDLE);

endmodule

// File: tb/tb_tqvp_bus_initiator.sv
// tb_tqvp_bus_initiator
// Directed bench for tqvp_bus_initiator: reset values, write/read timing,
// size masking, FIFO back-pressure and ordering, illegal size, optional
// read timeout, and asynchronous reset during a held read.
module tb_tqvp_bus_initiator;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [1:0]  cmd_size;
  logic [5:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_status;
  logic [5:0]  periph_address;
  logic [31:0] periph_data_in;
  logic [1:0]  periph_data_write_n;
  logic [1:0]  periph_data_read_n;
  logic [31:0] periph_data_out;
  logic        periph_data_ready;
  logic        busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        w;
    logic [1:0]  s;
    logic [5:0]  a;
    logic [31:0] d;
  } tcmd_t;

  always #5 clk = ~clk;

  tqvp_bus_initiator #(.FIFO_DEPTH(4), .TIMEOUT(15)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .cmd_valid           (cmd_valid),
    .cmd_ready           (cmd_ready),
    .cmd_write           (cmd_write),
    .cmd_size            (cmd_size),
    .cmd_addr            (cmd_addr),
    .cmd_wdata           (cmd_wdata),
    .rsp_valid           (rsp_valid),
    .rsp_ready           (rsp_ready),
    .rsp_rdata           (rsp_rdata),
    .rsp_status          (rsp_status),
    .periph_address      (periph_address),
    .periph_data_in      (periph_data_in),
    .periph_data_write_n (periph_data_write_n),
    .periph_data_read_n  (periph_data_read_n),
    .periph_data_out     (periph_data_out),
    .periph_data_ready   (periph_data_ready),
    .busy                (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_cmd(input logic w, input logic [1:0] s, input logic [5:0] a, input logic [31:0] d);
    cmd_write = w;
    cmd_size  = s;
    cmd_addr  = a;
    cmd_wdata = d;
  endtask

  // Offer one command for one edge (caller ensures the FIFO has room).
  task automatic push(input logic w, input logic [1:0] s, input logic [5:0] a, input logic [31:0] d);
    set_cmd(w, s, a, d);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=still running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tcmd_t       b [5];
    logic [31:0] exp_rdata [6];
    logic [5:0]  exp_addr  [5];
    int          n_rsp;
    int          n_acc;
    int          last;
    int          active;
    logic        accept;

    rst               = 1'b1;
    cmd_valid         = 1'b0;
    rsp_ready         = 1'b0;
    periph_data_out   = '0;
    periph_data_ready = 1'b0;
    set_cmd(1'b0, 2'b00, 6'd0, 32'h0);

    // ---------------- reset values (before any clock edge) ----------------
    #1;
    check("rst_cmd_ready",  32'(cmd_ready), 32'h1);
    check("rst_rsp_valid",  32'(rsp_valid), 32'h0);
    check("rst_rsp_rdata",  rsp_rdata, 32'h0);
    check("rst_rsp_status", 32'(rsp_status), 32'h0);
    check("rst_busy",       32'(busy), 32'h0);
    check("rst_addr",       32'(periph_address), 32'h0);
    check("rst_data_in",    periph_data_in, 32'h0);
    check("rst_strobes",    32'({periph_data_write_n, periph_data_read_n}), 32'hF);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // ---------------- 32-bit write, rsp_ready high ----------------
    rsp_ready = 1'b1;
    push(1'b1, 2'b10, 6'd1, 32'hDEADBEEF);              // accepted at E0
    check("wr_e0_strobe", 32'(periph_data_write_n), 32'h3);
    check("wr_e0_busy",   32'(busy), 32'h1);
    tick();                                             // E1
    check("wr_e1_write_n", 32'(periph_data_write_n), 32'h2);
    check("wr_e1_read_n",  32'(periph_data_read_n), 32'h3);
    check("wr_e1_addr",    32'(periph_address), 32'h1);
    check("wr_e1_data",    periph_data_in, 32'hDEADBEEF);
    check("wr_e1_rsp",     32'(rsp_valid), 32'h0);
    tick();                                             // E2
    check("wr_e2_write_n", 32'(periph_data_write_n), 32'h3);
    check("wr_e2_addr",    32'(periph_address), 32'h0);
    check("wr_e2_data",    periph_data_in, 32'h0);
    check("wr_e2_rsp",     32'(rsp_valid), 32'h1);
    check("wr_e2_status",  32'(rsp_status), 32'h0);
    check("wr_e2_rdata",   rsp_rdata, 32'h0);
    tick();                                             // handshake
    check("wr_done_rsp",  32'(rsp_valid), 32'h0);
    check("wr_done_busy", 32'(busy), 32'h0);

    // ---------------- 16-bit read, data_ready already high ----------------
    periph_data_out   = 32'h12345678;
    periph_data_ready = 1'b1;
    push(1'b0, 2'b01, 6'd9, 32'h0);
    tick();
    check("rd16_read_n", 32'(periph_data_read_n), 32'h1);
    check("rd16_addr",   32'(periph_address), 32'd9);
    tick();
    check("rd16_rsp",    32'(rsp_valid), 32'h1);
    check("rd16_rdata",  rsp_rdata, 32'h00005678);
    check("rd16_strobe", 32'(periph_data_read_n), 32'h3);
    periph_data_ready = 1'b0;
    tick();

    // ---------------- 8-bit read, data_ready delayed 3 cycles ----------------
    push(1'b0, 2'b00, 6'd3, 32'h0);
    tick();
    check("rd8_addr", 32'(periph_address), 32'd3);
    for (int i = 0; i < 4; i++) begin
      check("rd8_strobe_held", 32'(periph_data_read_n), 32'h0);
      check("rd8_no_rsp",      32'(rsp_valid), 32'h0);
      if (i == 3) periph_data_ready = 1'b1;
      tick();
    end
    check("rd8_strobe_off", 32'(periph_data_read_n), 32'h3);
    check("rd8_rsp",        32'(rsp_valid), 32'h1);
    check("rd8_rdata",      rsp_rdata, 32'h00000078);
    check("rd8_status",     32'(rsp_status), 32'h0);
    periph_data_ready = 1'b0;
    tick();

    // ---------------- FIFO fill, back-pressure, ordering ----------------
    rsp_ready         = 1'b0;
    periph_data_ready = 1'b1;
    periph_data_out   = 32'hCAFEF00D;
    push(1'b1, 2'b10, 6'd10, 32'hA);                    // A parks in RESP
    tick();
    tick();
    check("fill_a_parked", 32'(rsp_valid), 32'h1);
    b[0] = '{w: 1'b0, s: 2'b10, a: 6'd11, d: 32'h0};
    b[1] = '{w: 1'b1, s: 2'b01, a: 6'd12, d: 32'h1234};
    b[2] = '{w: 1'b0, s: 2'b00, a: 6'd13, d: 32'h0};
    b[3] = '{w: 1'b0, s: 2'b01, a: 6'd14, d: 32'h0};
    b[4] = '{w: 1'b1, s: 2'b00, a: 6'd15, d: 32'h55};
    exp_rdata = '{32'h0, 32'hCAFEF00D, 32'h0, 32'h0000000D, 32'h0000F00D, 32'h0};
    exp_addr  = '{6'd11, 6'd12, 6'd13, 6'd14, 6'd15};
    for (int i = 0; i < 4; i++) begin
      check("fill_ready", 32'(cmd_ready), 32'h1);
      push(b[i].w, b[i].s, b[i].a, b[i].d);
    end
    check("fill_full", 32'(cmd_ready), 32'h0);
    set_cmd(b[4].w, b[4].s, b[4].a, b[4].d);
    cmd_valid = 1'b1;
    tick();
    check("fill_still_full", 32'(cmd_ready), 32'h0);
    check("fill_busy",       32'(busy), 32'h1);
    rsp_ready = 1'b1;
    n_rsp = 0;
    n_acc = 0;
    last  = 0;
    for (int c = 0; c < 40 && n_rsp < 6; c++) begin
      if (periph_data_read_n != 2'b11 || periph_data_write_n != 2'b11) begin
        if (n_acc < 5) check("fill_addr", 32'(periph_address), 32'(exp_addr[n_acc]));
        else           check("fill_extra_access", n_acc, 32'd4);
        n_acc++;
      end
      if (rsp_valid) begin
        check("fill_rdata", rsp_rdata, exp_rdata[n_rsp]);
        if (n_rsp > 0) check("fill_gap", c - last, 32'd2);
        last = c;
        n_rsp++;
      end
      accept = cmd_valid && cmd_ready;
      tick();
      if (accept) cmd_valid = 1'b0;
    end
    check("fill_rsp_count", n_rsp, 32'd6);
    check("fill_acc_count", n_acc, 32'd5);
    check("fill_done_busy", 32'(busy), 32'h0);
    cmd_valid         = 1'b0;
    periph_data_ready = 1'b0;

    // ---------------- illegal size ----------------
    push(1'b0, 2'b11, 6'd20, 32'h0);
    check("ill_e0_strobes", 32'({periph_data_write_n, periph_data_read_n}), 32'hF);
    tick();
    check("ill_strobes", 32'({periph_data_write_n, periph_data_read_n}), 32'hF);
    check("ill_addr",    32'(periph_address), 32'h0);
    check("ill_rsp",     32'(rsp_valid), 32'h1);
    check("ill_status",  32'(rsp_status), 32'h2);
    check("ill_rdata",   rsp_rdata, 32'h0);
    tick();
    check("ill_done_rsp", 32'(rsp_valid), 32'h0);
    check("ill_done_strobes", 32'({periph_data_write_n, periph_data_read_n}), 32'hF);

`ifdef TQVP_BUS_INITIATOR_TIMEOUT_EN
    // ---------------- read timeout, then data on the last cycle ----------------
    periph_data_out = 32'h0BADCAFE;
    for (int r = 0; r < 2; r++) begin
      periph_data_ready = 1'b0;
      push(1'b0, 2'b10, 6'd2, 32'h0);
      tick();
      active = 0;
      for (int c = 0; c < 40; c++) begin
        if (periph_data_read_n == 2'b11) break;
        active++;
        if (r == 1 && active == 15) periph_data_ready = 1'b1;
        tick();
      end
      check("tmo_active_cycles", active, 32'd15);
      check("tmo_rsp",    32'(rsp_valid), 32'h1);
      check("tmo_status", 32'(rsp_status), (r == 0) ? 32'h1 : 32'h0);
      check("tmo_rdata",  rsp_rdata, (r == 0) ? 32'h0 : 32'h0BADCAFE);
      periph_data_ready = 1'b0;
      tick();
    end
`endif

    // ---------------- asynchronous reset during a held read ----------------
    rsp_ready         = 1'b0;
    periph_data_ready = 1'b0;
    push(1'b0, 2'b10, 6'd5, 32'h0);
    tick();
    check("arst_pre_strobe", 32'(periph_data_read_n), 32'h2);
    #2;
    rst = 1'b1;
    #1;
    check("arst_read_n",  32'(periph_data_read_n), 32'h3);
    check("arst_write_n", 32'(periph_data_write_n), 32'h3);
    check("arst_addr",    32'(periph_address), 32'h0);
    check("arst_rsp",     32'(rsp_valid), 32'h0);
    check("arst_busy",    32'(busy), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    periph_data_ready = 1'b1;
    tick();
    tick();
    check("arst_after_rsp",    32'(rsp_valid), 32'h0);
    check("arst_after_strobe", 32'(periph_data_read_n), 32'h3);
    check("arst_after_busy",   32'(busy), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
